// File: rtl/comparador_serial_bytes_pkg.sv
// Shared definitions for the byte-serial magnitude comparator.
package comparador_serial_bytes_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned FLAGS_W = 3;

   // Flag-vector bit positions
   localparam int unsigned IGUAL = 0;
   localparam int unsigned MAYOR = 1;
   localparam int unsigned MENOR = 2;

   // FSM encodings
   localparam logic [0:0] ESPERA  = 1'b0;
   localparam logic [0:0] COMPARA = 1'b1;

   // Cascade value loaded at the start of an operation: "equal so far"
   localparam logic [FLAGS_W-1:0] FLAGS_IGUAL = FLAGS_W'(1) << IGUAL;

endpackage

// File: rtl/Comparador8bits.sv
// 8-bit cascade comparator slice: a local difference wins, otherwise the cascade passes through.
module Comparador8bits
   import comparador_serial_bytes_pkg::*;
(
   input  logic [BYTE_W-1:0]  a,
   input  logic [BYTE_W-1:0]  b,
   input  logic [FLAGS_W-1:0] cascada,
   output logic [FLAGS_W-1:0] resultado_c
);

   // Local byte comparison overriding the incoming cascade
   always_comb begin
      resultado_c = cascada;
      if (a > b) begin
         resultado_c        = '0;
         resultado_c[MAYOR] = 1'b1;
      end else if (a < b) begin
         resultado_c        = '0;
         resultado_c[MENOR] = 1'b1;
      end
   end

endmodule

// File: rtl/comparador_serial_bytes.sv
// Multi-byte magnitude comparator processing one byte per clock, LSB byte first.
module comparador_serial_bytes
   import comparador_serial_bytes_pkg::*;
#(
   parameter int unsigned BYTES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    inicio,
   input  logic                    signo,
   input  logic [BYTE_W*BYTES-1:0] a,
   input  logic [BYTE_W*BYTES-1:0] b,
   output logic                    ocupado,
   output logic                    listo,
   output logic                    igual_o,
   output logic                    mayor_o,
   output logic                    menor_o
);

   localparam int unsigned OP_W  = BYTE_W * BYTES;
   localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0] IDX_ULTIMO = IDX_W'(BYTES - 1);

   logic [0:0]         estado,    estado_d;
   logic [IDX_W-1:0]   idx,       idx_d;
   logic [OP_W-1:0]    op_a,      op_a_d;
   logic [OP_W-1:0]    op_b,      op_b_d;
   logic               signo_r,   signo_d;
   logic [FLAGS_W-1:0] cascada,   cascada_d;
   logic [FLAGS_W-1:0] resultado, resultado_d;
   logic               ocupado_d, listo_d;

   logic               ultimo_c;
   logic [BYTE_W-1:0]  byte_a_c, byte_b_c;
   logic [FLAGS_W-1:0] slice_c;

   // Current byte sits at the bottom of the shifting operand registers;
   // in signed mode the top byte gets its sign bit flipped to bias the compare
   always_comb begin
      ultimo_c = (idx == IDX_ULTIMO);
      byte_a_c = op_a[BYTE_W-1:0];
      byte_b_c = op_b[BYTE_W-1:0];
      if (signo_r && ultimo_c) begin
         byte_a_c[BYTE_W-1] = ~byte_a_c[BYTE_W-1];
         byte_b_c[BYTE_W-1] = ~byte_b_c[BYTE_W-1];
      end
   end

   Comparador8bits u_slice (
      .a           (byte_a_c),
      .b           (byte_b_c),
      .cascada     (cascada),
      .resultado_c (slice_c)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado    <= ESPERA;
         idx       <= '0;
         op_a      <= '0;
         op_b      <= '0;
         signo_r   <= 1'b0;
         cascada   <= FLAGS_IGUAL;
         resultado <= '0;
         ocupado   <= 1'b0;
         listo     <= 1'b0;
      end else begin
         estado    <= estado_d;
         idx       <= idx_d;
         op_a      <= op_a_d;
         op_b      <= op_b_d;
         signo_r   <= signo_d;
         cascada   <= cascada_d;
         resultado <= resultado_d;
         ocupado   <= ocupado_d;
         listo     <= listo_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      estado_d    = estado;
      idx_d       = idx;
      op_a_d      = op_a;
      op_b_d      = op_b;
      signo_d     = signo_r;
      cascada_d   = cascada;
      resultado_d = resultado;
      ocupado_d   = ocupado;
      listo_d     = 1'b0;

      case (estado)
         ESPERA: begin
            if (inicio) begin
               op_a_d    = a;
               op_b_d    = b;
               signo_d   = signo;
               idx_d     = '0;
               cascada_d = FLAGS_IGUAL;
               ocupado_d = 1'b1;
               estado_d  = COMPARA;
            end
         end
         COMPARA: begin
            cascada_d = slice_c;
            idx_d     = idx + IDX_W'(1);
            op_a_d    = op_a >> BYTE_W;
            op_b_d    = op_b >> BYTE_W;
            if (ultimo_c) begin
               resultado_d = slice_c;
               listo_d     = 1'b1;
               ocupado_d   = 1'b0;
               estado_d    = ESPERA;
            end
         end
         default: estado_d = ESPERA;
      endcase
   end

   assign igual_o = resultado[IGUAL];
   assign mayor_o = resultado[MAYOR];
   assign menor_o = resultado[MENOR];

endmodule
